intc_vector_dispatch: RTL and testbench

Interrupt-controller core that sits directly downstream of the ISR address-config decoder. It takes the decoder's 2-bit register select and writes ISR vector addresses into a 4-entry vector file. It edge-detects and latches four interrupt request lines and arbitrates among them by fixed priority. It then runs a request/acknowledge/end-of-interrupt handshake with the CPU, presenting the winning source's ISR address.

---
 rtl/intc_pkg.sv | 16 +
 rtl/intc_priority_encoder.sv | 22 ++
 rtl/intc_vector_dispatch.sv | 112 +++++++++++
 tb/tb_intc_vector_dispatch.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// Shared types and sizes for the interrupt controller (ISR config decoder and vector dispatch).
package intc_pkg;

    localparam int unsigned NUM_IRQ   = 4;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned ISR_SEL_W = 2;

    localparam logic [ADDR_W-1:0] ISR_ADDR_RST = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/intc_priority_encoder.sv
// Fixed-priority picker over eligible interrupt sources; lowest index wins.
module intc_priority_encoder
    import intc_pkg::*;
(
    input  logic [NUM_IRQ-1:0]   eligible_i,
    output logic                 any_c_o,
    output logic [ISR_SEL_W-1:0] id_c_o
);

    // Scan from the top down so the lowest set index is written last.
    always_comb begin
        any_c_o = 1'b0;
        id_c_o  = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible_i[i]) begin
                any_c_o = 1'b1;
                id_c_o  = ISR_SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/intc_vector_dispatch.sv
// Vector file, edge-latched pending requests and the REQ/ACK/EOI dispatch handshake to the CPU.
module intc_vector_dispatch
    import intc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [ISR_SEL_W-1:0] cfg_select,
    input  logic [ADDR_W-1:0]    cfg_data,
    input  logic [NUM_IRQ-1:0]   irq_in,
    output logic                 cpu_intr,
    output logic [ADDR_W-1:0]    isr_addr,
    output logic [ISR_SEL_W-1:0] irq_id,
    input  logic                 cpu_ack,
    input  logic                 cpu_eoi,
    output logic [NUM_IRQ-1:0]   irq_pending,
    output logic [NUM_IRQ-1:0]   vec_valid
);

    state_t                 state_q;
    logic                   cpu_intr_q;
    logic [ADDR_W-1:0]      isr_addr_q;
    logic [ISR_SEL_W-1:0]   irq_id_q;
    logic [NUM_IRQ-1:0]     irq_q;
    logic [NUM_IRQ-1:0]     pending_q;
    logic [NUM_IRQ-1:0]     pending_d;
    logic [NUM_IRQ-1:0]     vec_valid_q;
    logic [ADDR_W-1:0]      vec_q [NUM_IRQ];

    logic [NUM_IRQ-1:0]     edge_c;
    logic [NUM_IRQ-1:0]     ack_clr_c;
    logic                   any_c;
    logic [ISR_SEL_W-1:0]   win_id_c;

    assign edge_c = irq_in & ~irq_q;

    // A fresh edge on the acked source outranks the clear.
    always_comb begin
        ack_clr_c = '0;
        if (state_q == REQ && cpu_ack) begin
            ack_clr_c[irq_id_q] = 1'b1;
        end
        pending_d = (pending_q & ~ack_clr_c) | edge_c;
    end

    intc_priority_encoder u_prio (
        .eligible_i (pending_q & vec_valid_q),
        .any_c_o    (any_c),
        .id_c_o     (win_id_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q       <= '0;
            pending_q   <= '0;
            vec_valid_q <= '0;
            for (int i = 0; i < int'(NUM_IRQ); i++) begin
                vec_q[i] <= '0;
            end
        end else begin
            irq_q     <= irq_in;
            pending_q <= pending_d;
            if (cfg_we) begin
                vec_q[cfg_select]       <= cfg_data;
                vec_valid_q[cfg_select] <= 1'b1;
            end
        end
    end

    // Dispatch FSM; isr_addr snapshots the vector at dispatch so later writes don't disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cpu_intr_q <= 1'b0;
            isr_addr_q <= ISR_ADDR_RST;
            irq_id_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_c) begin
                        state_q    <= REQ;
                        cpu_intr_q <= 1'b1;
                        irq_id_q   <= win_id_c;
                        isr_addr_q <= vec_q[win_id_c];
                    end
                end
                REQ: begin
                    if (cpu_ack) begin
                        state_q    <= SERVICE;
                        cpu_intr_q <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (cpu_eoi) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    cpu_intr_q <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_intr    = cpu_intr_q;
    assign isr_addr    = isr_addr_q;
    assign irq_id      = irq_id_q;
    assign irq_pending = pending_q;
    assign vec_valid   = vec_valid_q;

endmodule

// File: tb/tb_intc_vector_dispatch.sv
// Directed cycle-table bench for intc_vector_dispatch plus async-reset and latency sequences.
module tb_intc_vector_dispatch;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [1:0]  cfg_select;
    logic [31:0] cfg_data;
    logic [3:0]  irq_in;
    logic        cpu_intr;
    logic [31:0] isr_addr;
    logic [1:0]  irq_id;
    logic        cpu_ack;
    logic        cpu_eoi;
    logic [3:0]  irq_pending;
    logic [3:0]  vec_valid;

    int n_vec = 0;
    int n_err = 0;

    intc_vector_dispatch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_select  (cfg_select),
        .cfg_data    (cfg_data),
        .irq_in      (irq_in),
        .cpu_intr    (cpu_intr),
        .isr_addr    (isr_addr),
        .irq_id      (irq_id),
        .cpu_ack     (cpu_ack),
        .cpu_eoi     (cpu_eoi),
        .irq_pending (irq_pending),
        .vec_valid   (vec_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  sel;
        logic [31:0] data;
        logic [3:0]  irq;
        logic        ack;
        logic        eoi;
        logic        e_intr;
        logic [31:0] e_addr;
        logic [1:0]  e_id;
        logic [3:0]  e_pend;
        logic [3:0]  e_valid;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic we, logic [1:0] sel, logic [31:0] data, logic [3:0] irq,
                                logic ack, logic eoi, logic e_intr, logic [31:0] e_addr,
                                logic [1:0] e_id, logic [3:0] e_pend, logic [3:0] e_valid);
        vec_t v;
        v.we = we; v.sel = sel; v.data = data; v.irq = irq; v.ack = ack; v.eoi = eoi;
        v.e_intr = e_intr; v.e_addr = e_addr; v.e_id = e_id; v.e_pend = e_pend; v.e_valid = e_valid;
        return v;
    endfunction

    task automatic check(input string name, input logic e_intr, input logic [31:0] e_addr,
                         input logic [1:0] e_id, input logic [3:0] e_pend, input logic [3:0] e_valid);
        n_vec++;
        if ({cpu_intr, isr_addr, irq_id, irq_pending, vec_valid} !==
            {e_intr, e_addr, e_id, e_pend, e_valid}) begin
            n_err++;
            $display("FAIL %s: got intr=%b addr=%h id=%0d pend=%b valid=%b, want intr=%b addr=%h id=%0d pend=%b valid=%b",
                     name, cpu_intr, isr_addr, irq_id, irq_pending, vec_valid,
                     e_intr, e_addr, e_id, e_pend, e_valid);
        end
    endtask

    task automatic idle_inputs();
        cfg_we = 1'b0; cfg_select = 2'd0; cfg_data = '0; irq_in = '0; cpu_ack = 1'b0; cpu_eoi = 1'b0;
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        idle_inputs();

        // Cycle table: inputs held for one clock; expectations are outputs after that edge.
        //                we sel data          irq    ack eoi  intr addr          id pend   valid
        tbl.push_back(mk(1, 0, 32'h0000_1000, 4'b0000, 0, 0,  0, 32'h0,         0, 4'b0000, 4'b0001));
        tbl.push_back(mk(1, 2, 32'h0000_3000, 4'b0000, 0, 0,  0, 32'h0,         0, 4'b0000, 4'b0101));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0100, 0, 0,  0, 32'h0,         0, 4'b0100, 4'b0101));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 0, 0,  1, 32'h0000_3000, 2, 4'b0100, 4'b0101));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 1, 0,  0, 32'h0000_3000, 2, 4'b0000, 4'b0101));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 0, 0,  0, 32'h0000_3000, 2, 4'b0000, 4'b0101));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 0, 1,  0, 32'h0000_3000, 2, 4'b0000, 4'b0101));
        // Simultaneous sources 0 and 2
        tbl.push_back(mk(0, 0, 32'h0,         4'b0101, 0, 0,  0, 32'h0000_3000, 2, 4'b0101, 4'b0101));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 0, 0,  1, 32'h0000_1000, 0, 4'b0101, 4'b0101));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 1, 0,  0, 32'h0000_1000, 0, 4'b0100, 4'b0101));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 0, 1,  0, 32'h0000_1000, 0, 4'b0100, 4'b0101));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 0, 0,  1, 32'h0000_3000, 2, 4'b0100, 4'b0101));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 1, 1,  0, 32'h0000_3000, 2, 4'b0000, 4'b0101));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 0, 1,  0, 32'h0000_3000, 2, 4'b0000, 4'b0101));
        // Unconfigured source 3, stray eoi/ack in IDLE, then configure it
        tbl.push_back(mk(0, 0, 32'h0,         4'b1000, 0, 0,  0, 32'h0000_3000, 2, 4'b1000, 4'b0101));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 0, 1,  0, 32'h0000_3000, 2, 4'b1000, 4'b0101));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 1, 0,  0, 32'h0000_3000, 2, 4'b1000, 4'b0101));
        tbl.push_back(mk(1, 3, 32'h0000_4000, 4'b0000, 0, 0,  0, 32'h0000_3000, 2, 4'b1000, 4'b1101));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 0, 0,  1, 32'h0000_4000, 3, 4'b1000, 4'b1101));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 1, 0,  0, 32'h0000_4000, 3, 4'b0000, 4'b1101));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 0, 1,  0, 32'h0000_4000, 3, 4'b0000, 4'b1101));
        // Vector rewrite while in REQ keeps the snapshot
        tbl.push_back(mk(1, 1, 32'h0000_2000, 4'b0010, 0, 0,  0, 32'h0000_4000, 3, 4'b0010, 4'b1111));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 0, 0,  1, 32'h0000_2000, 1, 4'b0010, 4'b1111));
        tbl.push_back(mk(1, 1, 32'h0000_2200, 4'b0000, 0, 0,  1, 32'h0000_2000, 1, 4'b0010, 4'b1111));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 1, 0,  0, 32'h0000_2000, 1, 4'b0000, 4'b1111));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 0, 1,  0, 32'h0000_2000, 1, 4'b0000, 4'b1111));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0010, 0, 0,  0, 32'h0000_2000, 1, 4'b0010, 4'b1111));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 0, 0,  1, 32'h0000_2200, 1, 4'b0010, 4'b1111));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 1, 0,  0, 32'h0000_2200, 1, 4'b0000, 4'b1111));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 0, 1,  0, 32'h0000_2200, 1, 4'b0000, 4'b1111));
        // Write on the IDLE->REQ edge: the latch sees the old vector
        tbl.push_back(mk(0, 0, 32'h0,         4'b0010, 0, 0,  0, 32'h0000_2200, 1, 4'b0010, 4'b1111));
        tbl.push_back(mk(1, 1, 32'h0000_2300, 4'b0000, 0, 0,  1, 32'h0000_2200, 1, 4'b0010, 4'b1111));
        // Re-edge on the ack cycle: set beats clear
        tbl.push_back(mk(0, 0, 32'h0,         4'b0010, 1, 0,  0, 32'h0000_2200, 1, 4'b0010, 4'b1111));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 0, 0,  0, 32'h0000_2200, 1, 4'b0010, 4'b1111));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 0, 1,  0, 32'h0000_2200, 1, 4'b0010, 4'b1111));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 0, 0,  1, 32'h0000_2300, 1, 4'b0010, 4'b1111));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 1, 0,  0, 32'h0000_2300, 1, 4'b0000, 4'b1111));
        // Park in SERVICE with two sources pending
        tbl.push_back(mk(0, 0, 32'h0,         4'b0110, 0, 0,  0, 32'h0000_2300, 1, 4'b0110, 4'b1111));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 0, 0,  0, 32'h0000_2300, 1, 4'b0110, 4'b1111));

        #3;
        check("reset_state", 1'b0, 32'h0, 2'd0, 4'b0000, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            cfg_we = tbl[i].we; cfg_select = tbl[i].sel; cfg_data = tbl[i].data;
            irq_in = tbl[i].irq; cpu_ack = tbl[i].ack; cpu_eoi = tbl[i].eoi;
            @(posedge clk);
            #1;
            check($sformatf("row%0d", i), tbl[i].e_intr, tbl[i].e_addr, tbl[i].e_id,
                  tbl[i].e_pend, tbl[i].e_valid);
        end

        // Async reset mid-cycle while in SERVICE
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 1'b0, 32'h0, 2'd0, 4'b0000, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        cpu_ack = 1'b1;
        cpu_eoi = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("stray_after_reset%0d", i), 1'b0, 32'h0, 2'd0, 4'b0000, 4'b0000);
        end

        // Request-to-intr latency measured with a bounded wait
        @(negedge clk);
        idle_inputs();
        cfg_we = 1'b1; cfg_select = 2'd2; cfg_data = 32'h0000_5000;
        @(negedge clk);
        idle_inputs();
        irq_in = 4'b0100;
        cyc = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            irq_in = 4'b0000;
            if (cpu_intr) begin
                cyc = i;
                break;
            end
        end
        n_vec++;
        if (cyc != 2) begin
            n_err++;
            $display("FAIL latency: cpu_intr after %0d cycles (0 = timeout), want 2", cyc);
        end
        check("latency_dispatch", 1'b1, 32'h0000_5000, 2'd2, 4'b0100, 4'b0100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
